config_scan_register: RTL and testbench
=======================================

CONFIG_SCAN_REGISTER -- requirements
Module: config_scan_register

Interface
REQ-001 Parameter WIDTH, default 8, number of configuration bits held (legal range 2..64).
REQ-002 Parameter RESET_VALUE, default 0, WIDTH-bit value loaded into chain and shadow on reset.
REQ-003 Parameter STRICT, default 1, 1 = reject updates after an incomplete shift, 0 = perform them but flag.
REQ-004 clk  input  1  single clock; all state on rising edge except lockup stage (REQ-012).
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 chain_in  input  1  serial data in from previous chain element.
REQ-007 enable  input  1  shift enable.
REQ-008 capture  input  1  reload chain from shadow for readback.
REQ-009 update  input  1  single-cycle strobe copying chain into shadow.
REQ-010 chain_out  output  1  serial data out to next chain element.
REQ-011 bits_out  output  WIDTH  shadow (applied) configuration word; count_ok output 1, count == WIDTH; update_error output 1, sticky error flag.

Function
REQ-012 chain_out SHALL be chain[WIDTH-1] retimed on the falling edge of clk (lockup stage, half-cycle hold margin).
REQ-013 enable=1: chain <= {chain[WIDTH-2:0], chain_in}; first bit shifted in reaches chain_out after WIDTH shifts (MSB-first).
REQ-014 enable=0, capture=1: chain <= shadow; enable=0, capture=0: chain holds.
REQ-015 enable=1 and capture=1 same cycle: shift wins, capture ignored, no error.
REQ-016 update=1: shadow <= chain value before any same-cycle shift; bits_out = shadow, registered, visible cycle after strobe.
REQ-017 Counter of shifted bits since last update/capture, saturating at WIDTH+1; cleared on every update strobe and every performed capture; enable in the same cycle as a clearing update leaves count at 1.
REQ-018 count_ok SHALL be combinational (count == WIDTH).
REQ-019 update with count != WIDTH: STRICT=1 -> shadow unchanged, update_error <= 1; STRICT=0 -> shadow updated, update_error <= 1.
REQ-020 update with count == WIDTH: shadow updated, update_error unchanged.
REQ-021 update_error SHALL remain set until reset; no other clear path.
REQ-022 update held high multiple cycles: each cycle treated as a separate strobe (second cycle sees count 0 or 1 -> error per REQ-019).
REQ-023 Shifting more than WIDTH bits: chain keeps last WIDTH bits; count saturates at WIDTH+1, count_ok=0.

Reset
REQ-024 reset=1 at rising edge: chain <= RESET_VALUE, shadow <= RESET_VALUE, count <= 0, update_error <= 0; reset overrides enable/capture/update.
REQ-025 bits_out = RESET_VALUE from the first cycle after reset; chain_out = RESET_VALUE[WIDTH-1] after following falling edge.
REQ-026 Reset mid-shift SHALL discard partial data; shadow not modified by the interrupted sequence.

Structure
REQ-027 Package config_scan_pkg SHALL hold count-width function (clog2(WIDTH+2)) and the STRICT mode constants.
REQ-028 Falling-edge lockup stage SHALL be sub-module scan_lockup (1-bit, no reset); remainder in one module.

Verification (WIDTH=8, RESET_VALUE=8'h00 unless stated)
REQ-029 Reset, shift 8'hA5 MSB-first, update -> bits_out=8'hA5, count_ok=1 before strobe, update_error=0.
REQ-030 STRICT=1: shift 5 bits, update -> bits_out unchanged 8'h00, update_error=1, stays 1 through later good update of 8'h3C (bits_out=8'h3C).
REQ-031 Load 8'hC3, update, shift 8'hFF, capture, shift 8 bits -> chain_out sequence 1,1,0,0,0,0,1,1 (readback of shadow).
REQ-032 Two chained instances, shift 16 bits 16'h1234, update both -> bits_out 8'h12 (far) and 8'h34 (near); no hold race at lockup.
REQ-033 enable+update same cycle after 8 shifts of 8'h81 -> shadow=8'h81 (pre-shift), count=1; enable+capture same cycle -> shift only.
REQ-034 RESET_VALUE=8'h5A, reset asserted after 4 shifts -> chain=shadow=8'h5A, count=0, update_error=0.

Source files
------------

// File: rtl/config_scan_pkg.sv
// Shared constants and sizing helper for the configuration scan register.
package config_scan_pkg;

  localparam bit STRICT_REJECT = 1'b1;  // incomplete-shift updates are dropped
  localparam bit STRICT_FLAG   = 1'b0;  // incomplete-shift updates are applied but flagged

  // Counter must hold 0..WIDTH+1 (WIDTH+1 marks an over-shift).
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/scan_lockup.sv
// Falling-edge retiming latch between chain elements; gives the next element half a cycle of hold margin.
module scan_lockup (
  input  logic clk,
  input  logic d,
  output logic q
);

  always_ff @(negedge clk) q <= d;

endmodule

// File: rtl/config_scan_register.sv
// Serial configuration register: shift chain, shadow word applied on update, readback via capture.
module config_scan_register
  import config_scan_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               STRICT      = STRICT_REJECT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chain_in,
  input  logic             enable,
  input  logic             capture,
  input  logic             update,
  output logic             chain_out,
  output logic [WIDTH-1:0] bits_out,
  output logic             count_ok,
  output logic             update_error
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

  logic [WIDTH-1:0] chain;
  logic [WIDTH-1:0] shadow;
  logic [CW-1:0]    count;

  assign count_ok = (count == CNT_FULL);
  assign bits_out = shadow;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain        <= RESET_VALUE;
      shadow       <= RESET_VALUE;
      count        <= '0;
      update_error <= 1'b0;
    end else begin
      // Update samples the chain as it stood before any same-cycle shift.
      if (update) begin
        if (count_ok || !STRICT) shadow <= chain;
        if (!count_ok)           update_error <= 1'b1;
      end

      if (enable)       chain <= {chain[WIDTH-2:0], chain_in};
      else if (capture) chain <= shadow;

      // A shift alongside a clearing update counts as the first bit of the next load.
      if (update)       count <= enable ? CW'(1) : '0;
      else if (enable) begin
        if (count != CNT_SAT) count <= count + CW'(1);
      end
      else if (capture) count <= '0;
    end
  end

  scan_lockup u_lockup (
    .clk (clk),
    .d   (chain[WIDTH-1]),
    .q   (chain_out)
  );

endmodule

// File: tb/tb_config_scan_register.sv
// Randomized + directed bench for config_scan_register with a per-cycle scoreboard against a word-level model.
module tb_config_scan_register;
  import config_scan_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1, chain_in = 1'b0, enable = 1'b0, capture = 1'b0, update = 1'b0;
  always #5 clk = ~clk;

  // Three configurations share stimulus: strict/0, flag/0, strict/5A.
  logic [2:0][7:0] bo;
  logic [2:0]      ok, er, co;

  config_scan_register #(.WIDTH(8), .RESET_VALUE(8'h00), .STRICT(STRICT_REJECT)) u_dut (
    .clk(clk), .reset(reset), .chain_in(chain_in), .enable(enable), .capture(capture),
    .update(update), .chain_out(co[0]), .bits_out(bo[0]), .count_ok(ok[0]), .update_error(er[0]));
  config_scan_register #(.WIDTH(8), .RESET_VALUE(8'h00), .STRICT(STRICT_FLAG)) u_lax (
    .clk(clk), .reset(reset), .chain_in(chain_in), .enable(enable), .capture(capture),
    .update(update), .chain_out(co[1]), .bits_out(bo[1]), .count_ok(ok[1]), .update_error(er[1]));
  config_scan_register #(.WIDTH(8), .RESET_VALUE(8'h5A), .STRICT(STRICT_REJECT)) u_rv (
    .clk(clk), .reset(reset), .chain_in(chain_in), .enable(enable), .capture(capture),
    .update(update), .chain_out(co[2]), .bits_out(bo[2]), .count_ok(ok[2]), .update_error(er[2]));

  // Two-element chain: near takes the bench serial stream, far takes near's lockup output.
  logic [7:0] near_bo, far_bo;
  logic       near_co, far_co, near_ok, far_ok, near_er, far_er;
  config_scan_register #(.WIDTH(8), .RESET_VALUE(8'h00), .STRICT(STRICT_FLAG)) u_near (
    .clk(clk), .reset(reset), .chain_in(chain_in), .enable(enable), .capture(capture),
    .update(update), .chain_out(near_co), .bits_out(near_bo), .count_ok(near_ok), .update_error(near_er));
  config_scan_register #(.WIDTH(8), .RESET_VALUE(8'h00), .STRICT(STRICT_FLAG)) u_far (
    .clk(clk), .reset(reset), .chain_in(near_co), .enable(enable), .capture(capture),
    .update(update), .chain_out(far_co), .bits_out(far_bo), .count_ok(far_ok), .update_error(far_er));

  typedef struct {
    logic [2:0][7:0] bo;
    logic [2:0]      ok, er, co;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_x;
  int   n_vec = 0, n_bad = 0;

  // Word-level reference state per configuration.
  int m_chain[3], m_shadow[3], m_cnt[3];
  bit m_err[3];
  int rv_of[3]  = '{0, 0, 'h5A};
  bit str_of[3] = '{1'b1, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit c, input bit u, input bit d);
    exp_t x;
    int   nc, ns, nn;
    @(negedge clk); #2;
    reset = r; enable = e; capture = c; update = u; chain_in = d;
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_chain[i] = rv_of[i]; m_shadow[i] = rv_of[i]; m_cnt[i] = 0; m_err[i] = 1'b0;
      end else begin
        ns = m_shadow[i];
        if (u && (m_cnt[i] == 8 || !str_of[i])) ns = m_chain[i];
        if (u && m_cnt[i] != 8) m_err[i] = 1'b1;
        if (e)      nc = (m_chain[i] * 2 + int'(d)) % 256;
        else if (c) nc = m_shadow[i];
        else        nc = m_chain[i];
        if (u)      nn = e ? 1 : 0;
        else if (e) nn = (m_cnt[i] + 1 > 9) ? 9 : m_cnt[i] + 1;
        else if (c) nn = 0;
        else        nn = m_cnt[i];
        m_chain[i] = nc; m_shadow[i] = ns; m_cnt[i] = nn;
      end
      x.bo[i] = 8'(m_shadow[i]);
      x.ok[i] = (m_cnt[i] == 8);
      x.er[i] = m_err[i];
      x.co[i] = 1'((m_chain[i] >> 7) & 1);
    end
    sb_q.push_back(x);
  endtask

  task automatic shift_word(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, 1'b0, 1'b0, v[i]);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: one expected record per cycle, checked just after the lockup edge.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (sb_q.size() > 0) begin
        mon_x = sb_q.pop_front();
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("sb_bits_out[%0d]", i), bo[i], mon_x.bo[i]);
          chk($sformatf("sb_count_ok[%0d]", i), 8'(ok[i]), 8'(mon_x.ok[i]));
          chk($sformatf("sb_update_error[%0d]", i), 8'(er[i]), 8'(mon_x.er[i]));
          chk($sformatf("sb_chain_out[%0d]", i), 8'(co[i]), 8'(mon_x.co[i]));
        end
      end
    end
  end

  initial begin
    int p;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    idle();
    chk("reset_bits_out", bo[0], 8'h00);
    chk("reset_bits_out_rv", bo[2], 8'h5A);

    // Basic load of A5
    shift_word(16'h00A5, 8);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("load_a5_bits_out", bo[0], 8'hA5);
    chk("load_a5_error", 8'(er[0]), 8'h00);

    // Short shift then good load: error sticks
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    shift_word(16'h0015, 5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("short_bits_out", bo[0], 8'h00);
    chk("short_error", 8'(er[0]), 8'h01);
    shift_word(16'h003C, 8);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("good_after_bad_bits_out", bo[0], 8'h3C);
    chk("error_sticky", 8'(er[0]), 8'h01);

    // Capture readback of C3
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    shift_word(16'h00C3, 8);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    shift_word(16'h00FF, 8);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    shift_word(16'h0000, 8);

    // Two chained elements
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    shift_word(16'h1234, 16);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("chain_far_bits_out", far_bo, 8'h12);
    chk("chain_near_bits_out", near_bo, 8'h34);

    // Shift together with update / capture
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    shift_word(16'h0081, 8);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();
    chk("shift_update_bits_out", bo[0], 8'h81);
    chk("shift_update_count_ok", 8'(ok[0]), 8'h00);
    chk("shift_update_error", 8'(er[0]), 8'h00);
    shift_word(16'h0055, 7);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-shift
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    shift_word(16'h000F, 4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("midreset_bits_out", bo[2], 8'h5A);
    chk("midreset_error", 8'(er[2]), 8'h00);
    chk("midreset_count_ok", 8'(ok[2]), 8'h00);
    chk("midreset_chain_out", 8'(co[2]), 8'h00);
    shift_word(16'h0000, 8);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      p = int'($urandom_range(0, 99));
      step(p < 2, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 12, 1'($urandom));
    end
    idle();

    repeat (3) @(negedge clk);
    #5;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d records left, 0 required", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
